// File: rtl/mem_arbiter_pkg.sv
// Shared port identifiers, counter width and FSM encoding for the
// fetch/data unified-memory arbiter.
package mem_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int LAT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory macro.
// The arbiter uses the slave view; the core/memory side uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the parent owns the last-grant flop.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  logic [1:0] grant_s;

  // On a tie the port that did not win last time is served
  always_comb begin
    grant_s = 2'b00;
    case (req)
      2'b01: grant_s = 2'b01;
      2'b10: grant_s = 2'b10;
      2'b11: begin
        if (last == PORT_IF) begin
          grant_s = 2'b10;
        end else begin
          grant_s = 2'b01;
        end
      end
      default: grant_s = 2'b00;
    endcase
  end

  assign grant = grant_s;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the core's fetch and data ports onto one fixed-latency memory,
// one outstanding transaction at a time, with round-robin fairness.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  arb_state_e        state_r, next_state_s;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic              owner_r, owner_we_r, last_gnt_r;
  logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
  logic [1:0]        grant_s;

  logic              if_gnt_s, d_gnt_s, if_rvalid_s, d_rvalid_s;
  logic              mem_en_s, mem_we_s;
  logic [BE_W-1:0]   mem_be_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s, if_rdata_s, d_rdata_s;

  rr_arb2 u_rr_arb2 (
    .req   ({bus.d_req, bus.if_req}),
    .last  (last_gnt_r),
    .grant (grant_s)
  );

  // Grant/issue in IDLE, response steering on the last WAIT cycle
  always_comb begin
    next_state_s = state_r;
    if_gnt_s     = 1'b0;
    d_gnt_s      = 1'b0;
    if_rvalid_s  = 1'b0;
    d_rvalid_s   = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_be_s     = {BE_W{1'b0}};
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    if_rdata_s   = if_rdata_r;
    d_rdata_s    = d_rdata_r;
    // Requests held through reset must not leak a combinational grant
    if (rst) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s[PORT_D]) begin
            d_gnt_s      = 1'b1;
            mem_en_s     = 1'b1;
            mem_we_s     = bus.d_we;
            mem_be_s     = bus.d_be;
            mem_addr_s   = bus.d_addr;
            mem_wdata_s  = bus.d_wdata;
            next_state_s = WAIT;
          end else if (grant_s[PORT_IF]) begin
            if_gnt_s     = 1'b1;
            mem_en_s     = 1'b1;
            mem_be_s     = {BE_W{1'b1}};
            mem_addr_s   = bus.if_addr;
            next_state_s = WAIT;
          end else begin
            next_state_s = IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt_r == LAT_ONE) begin
            next_state_s = IDLE;
            if (owner_r == PORT_D) begin
              d_rvalid_s = 1'b1;
              d_rdata_s  = owner_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end else begin
              if_rvalid_s = 1'b1;
              if_rdata_s  = bus.mem_rdata;
            end
          end else begin
            next_state_s = WAIT;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // FSM state, latency countdown and ownership of the in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lat_cnt_r  <= {LAT_W{1'b0}};
      owner_r    <= PORT_IF;
      owner_we_r <= 1'b0;
      last_gnt_r <= PORT_IF;
    end else begin
      state_r <= next_state_s;
      if (mem_en_s) begin
        lat_cnt_r  <= LAT_INIT;
        owner_r    <= d_gnt_s ? PORT_D : PORT_IF;
        owner_we_r <= d_gnt_s & bus.d_we;
        last_gnt_r <= d_gnt_s ? PORT_D : PORT_IF;
      end else if (state_r == WAIT) begin
        lat_cnt_r <= lat_cnt_r - LAT_ONE;
      end
    end
  end

  // Per-port copy of the last response, presented between rvalid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      if (if_rvalid_s) begin
        if_rdata_r <= if_rdata_s;
      end
      if (d_rvalid_s) begin
        d_rdata_r <= d_rdata_s;
      end
    end
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.if_rvalid = if_rvalid_s;
  assign bus.d_rvalid  = d_rvalid_s;
  assign bus.if_rdata  = if_rdata_s;
  assign bus.d_rdata   = d_rdata_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_be    = mem_be_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.busy      = (state_r != IDLE);

endmodule
